// File: rtl/execute_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: instruction fields, forwarding
// selects/data, pipeline controls, and the EX/MEM register outputs.
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall_in;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_regA_data;
  logic [DATA_W-1:0] id_regB_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [3:0]        id_alu_op;
  logic [REG_W-1:0]  id_regD;
  logic              id_RegW_en;
  logic              id_mem_rd;
  logic              id_mem_wr;
  logic [1:0]        selMuxRegA;
  logic [1:0]        selMuxRegB;
  logic [DATA_W-1:0] mem_fwd_data;
  logic [DATA_W-1:0] wb_fwd_data;
  logic              ex_stall;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_W-1:0]  mem_regD;
  logic              mem_RegW_en;
  logic              mem_mem_rd;
  logic              mem_mem_wr;

  modport master (
    output stall_in, flush, id_valid, id_regA_data, id_regB_data, id_imm,
           id_use_imm, id_alu_op, id_regD, id_RegW_en, id_mem_rd, id_mem_wr,
           selMuxRegA, selMuxRegB, mem_fwd_data, wb_fwd_data,
    input  ex_stall, mem_valid, mem_alu_result, mem_store_data, mem_regD,
           mem_RegW_en, mem_mem_rd, mem_mem_wr
  );

  modport slave (
    input  stall_in, flush, id_valid, id_regA_data, id_regB_data, id_imm,
           id_use_imm, id_alu_op, id_regD, id_RegW_en, id_mem_rd, id_mem_wr,
           selMuxRegA, selMuxRegB, mem_fwd_data, wb_fwd_data,
    output ex_stall, mem_valid, mem_alu_result, mem_store_data, mem_regD,
           mem_RegW_en, mem_mem_rd, mem_mem_wr
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage: forwarded operand selection, single-cycle ALU, a DATA_W-iteration
// shift-add multiplier, and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          reset,
  execute_stage_if.slave ex
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  regd;
    logic              reg_w_en;
    logic              mem_rd;
    logic              mem_wr;
  } exmem_t;

  localparam exmem_t EXMEM_BUBBLE = {$bits(exmem_t){1'b0}};

  state_t            state_r;
  exmem_t            exmem_r;
  exmem_t            exmem_next_s;
  exmem_t            alu_load_s;
  exmem_t            mul_load_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] fwd_b_s;
  logic [DATA_W-1:0] opb_s;
  logic              accept_s;
  logic              ex_stall_s;
  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [DATA_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] lat_store_r;
  logic [REG_W-1:0]  lat_regd_r;
  logic              lat_rw_r;
  logic              lat_rd_r;
  logic              lat_wr_r;

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [4:0]        sh;
    logic [DATA_W-1:0] r;
    sh = b[4:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                             : {DATA_W{1'b0}};
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = DATA_W'($signed(a) >>> sh);
      // MUL never loads through this path; it goes through the iterative unit.
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // Forwarding muxes; the immediate only replaces the ALU B input, not store data.
  always_comb begin
    opa_s   = ex.id_regA_data;
    fwd_b_s = ex.id_regB_data;
    opb_s   = ex.id_regB_data;
    case (ex.selMuxRegA)
      2'b01:   opa_s = ex.wb_fwd_data;
      2'b10:   opa_s = ex.mem_fwd_data;
      default: opa_s = ex.id_regA_data;
    endcase
    case (ex.selMuxRegB)
      2'b01:   fwd_b_s = ex.wb_fwd_data;
      2'b10:   fwd_b_s = ex.mem_fwd_data;
      default: fwd_b_s = ex.id_regB_data;
    endcase
    if (ex.id_use_imm) begin
      opb_s = ex.id_imm;
    end else begin
      opb_s = fwd_b_s;
    end
  end

  // Multiply acceptance and the upstream stall request.
  always_comb begin
    accept_s   = 1'b0;
    ex_stall_s = 1'b0;
    if ((state_r == ST_IDLE) && ex.id_valid && (ex.id_alu_op == OP_MUL) &&
        !ex.flush && !ex.stall_in) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (reset) begin
      ex_stall_s = 1'b0;
    end else if (accept_s || (state_r == ST_BUSY)) begin
      ex_stall_s = 1'b1;
    end else begin
      ex_stall_s = 1'b0;
    end
  end

  // Candidate EX/MEM contents for a single-cycle op and for a finished multiply.
  always_comb begin
    alu_load_s          = EXMEM_BUBBLE;
    alu_load_s.valid    = 1'b1;
    alu_load_s.result   = alu_calc(ex.id_alu_op, opa_s, opb_s);
    alu_load_s.store    = fwd_b_s;
    alu_load_s.regd     = ex.id_regD;
    alu_load_s.reg_w_en = ex.id_RegW_en;
    alu_load_s.mem_rd   = ex.id_mem_rd;
    alu_load_s.mem_wr   = ex.id_mem_wr;

    mul_load_s          = EXMEM_BUBBLE;
    mul_load_s.valid    = 1'b1;
    mul_load_s.result   = acc_r;
    mul_load_s.store    = lat_store_r;
    mul_load_s.regd     = lat_regd_r;
    mul_load_s.reg_w_en = lat_rw_r;
    mul_load_s.mem_rd   = lat_rd_r;
    mul_load_s.mem_wr   = lat_wr_r;
  end

  // Next EX/MEM value: flush beats stall, stall holds, otherwise by FSM state.
  always_comb begin
    exmem_next_s = exmem_r;
    if (ex.flush) begin
      exmem_next_s = EXMEM_BUBBLE;
    end else if (ex.stall_in) begin
      exmem_next_s = exmem_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!ex.id_valid || (ex.id_alu_op == OP_MUL)) begin
            exmem_next_s = EXMEM_BUBBLE;
          end else begin
            exmem_next_s = alu_load_s;
          end
        end
        ST_BUSY: exmem_next_s = EXMEM_BUBBLE;
        ST_DONE: exmem_next_s = mul_load_s;
        default: exmem_next_s = EXMEM_BUBBLE;
      endcase
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_r <= EXMEM_BUBBLE;
    end else begin
      exmem_r <= exmem_next_s;
    end
  end

  // Multiply FSM with operand/control latches, accumulator and iteration count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mcand_r     <= {DATA_W{1'b0}};
      mplier_r    <= {DATA_W{1'b0}};
      acc_r       <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      lat_store_r <= {DATA_W{1'b0}};
      lat_regd_r  <= {REG_W{1'b0}};
      lat_rw_r    <= 1'b0;
      lat_rd_r    <= 1'b0;
      lat_wr_r    <= 1'b0;
    end else if (ex.flush) begin
      state_r <= ST_IDLE;
      acc_r   <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // Forwarded values may change while we stall, so capture them now.
            mcand_r     <= opa_s;
            mplier_r    <= opb_s;
            acc_r       <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            lat_store_r <= fwd_b_s;
            lat_regd_r  <= ex.id_regD;
            lat_rw_r    <= ex.id_RegW_en;
            lat_rd_r    <= ex.id_mem_rd;
            lat_wr_r    <= ex.id_mem_wr;
            state_r     <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (ex.stall_in) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign ex.ex_stall       = ex_stall_s;
  assign ex.mem_valid      = exmem_r.valid;
  assign ex.mem_alu_result = exmem_r.result;
  assign ex.mem_store_data = exmem_r.store;
  assign ex.mem_regD       = exmem_r.regd;
  assign ex.mem_RegW_en    = exmem_r.reg_w_en;
  assign ex.mem_mem_rd     = exmem_r.mem_rd;
  assign ex.mem_mem_wr     = exmem_r.mem_wr;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a cycle-count reference model.
module tb_execute_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  execute_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  execute_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected EX/MEM contents.
  logic        e_valid, e_rw, e_rd, e_wr;
  logic [31:0] e_res, e_store;
  logic [4:0]  e_regd;
  // Pending multiply: accepted in cycle m_start, product computed directly.
  bit          m_act;
  int          m_start;
  logic [31:0] m_prod, m_store;
  logic [4:0]  m_regd;
  logic        m_rw, m_rd, m_wr;
  int          cyc = 0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return 32'(int'(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'b01) return bus.wb_fwd_data;
    else if (sel == 2'b10) return bus.mem_fwd_data;
    else return regv;
  endfunction

  task automatic model_bubble();
    e_valid = 1'b0; e_res = 32'd0; e_store = 32'd0; e_regd = 5'd0;
    e_rw = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_act = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0] a, b, fb;
    a  = fwd(bus.selMuxRegA, bus.id_regA_data);
    fb = fwd(bus.selMuxRegB, bus.id_regB_data);
    b  = bus.id_use_imm ? bus.id_imm : fb;
    if (reset) begin
      model_reset();
    end else if (bus.flush) begin
      model_reset();
    end else if (m_act) begin
      if (cyc <= m_start + DATA_W) begin
        if (!bus.stall_in) model_bubble();
      end else if (!bus.stall_in) begin
        e_valid = 1'b1; e_res = m_prod; e_store = m_store; e_regd = m_regd;
        e_rw = m_rw; e_rd = m_rd; e_wr = m_wr;
        m_act = 1'b0;
      end
    end else if (!bus.stall_in) begin
      if (!bus.id_valid) begin
        model_bubble();
      end else if (bus.id_alu_op == 4'd9) begin
        m_act = 1'b1; m_start = cyc; m_prod = a * b; m_store = fb;
        m_regd = bus.id_regD; m_rw = bus.id_RegW_en; m_rd = bus.id_mem_rd; m_wr = bus.id_mem_wr;
        model_bubble();
      end else begin
        e_valid = 1'b1; e_res = ref_alu(bus.id_alu_op, a, b); e_store = fb;
        e_regd = bus.id_regD; e_rw = bus.id_RegW_en; e_rd = bus.id_mem_rd; e_wr = bus.id_mem_wr;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_nop();
    bus.id_valid = 1'b0; bus.id_regA_data = 32'd0; bus.id_regB_data = 32'd0;
    bus.id_imm = 32'd0; bus.id_use_imm = 1'b0; bus.id_alu_op = 4'd0; bus.id_regD = 5'd0;
    bus.id_RegW_en = 1'b0; bus.id_mem_rd = 1'b0; bus.id_mem_wr = 1'b0;
    bus.selMuxRegA = 2'b00; bus.selMuxRegB = 2'b00;
    bus.mem_fwd_data = 32'd0; bus.wb_fwd_data = 32'd0;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    set_nop();
    bus.id_valid = 1'b1; bus.id_alu_op = op; bus.id_regA_data = a; bus.id_regB_data = b;
    bus.id_regD = rd; bus.id_RegW_en = 1'b1;
  endtask

  // Counts ex_stall-high cycles from the accept cycle until DONE.
  task automatic run_mul(input int change_at, output int stall_cycles);
    stall_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.ex_stall) break;
      stall_cycles++;
      if (i > 0) chk("mul_bubble", 32'(bus.mem_valid), 32'd0);
      if (i == change_at) begin
        bus.selMuxRegA = 2'b10; bus.selMuxRegB = 2'b01;
        bus.mem_fwd_data = $urandom; bus.wb_fwd_data = $urandom;
        bus.id_regA_data = $urandom; bus.id_regB_data = $urandom; bus.id_regD = 5'd30;
      end
      step();
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic exp_stall;
    forever begin
      @(negedge clk);
      exp_stall = !reset && ((m_act && (cyc <= m_start + DATA_W)) ||
                  (!m_act && bus.id_valid && (bus.id_alu_op == 4'd9) && !bus.flush && !bus.stall_in));
      checks++;
      if (bus.ex_stall !== exp_stall) begin
        errors++;
        $display("FAIL ex_stall cyc=%0d: got %b want %b", cyc, bus.ex_stall, exp_stall);
      end
      checks++;
      if ({bus.mem_valid, bus.mem_alu_result, bus.mem_store_data, bus.mem_regD,
           bus.mem_RegW_en, bus.mem_mem_rd, bus.mem_mem_wr} !==
          {e_valid, e_res, e_store, e_regd, e_rw, e_rd, e_wr}) begin
        errors++;
        $display("FAIL exmem cyc=%0d: got v=%b res=%h st=%h rd=%0d ctl=%b%b%b want v=%b res=%h st=%h rd=%0d ctl=%b%b%b",
                 cyc, bus.mem_valid, bus.mem_alu_result, bus.mem_store_data, bus.mem_regD,
                 bus.mem_RegW_en, bus.mem_mem_rd, bus.mem_mem_wr,
                 e_valid, e_res, e_store, e_regd, e_rw, e_rd, e_wr);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    set_nop();
    model_reset();
    step();
    // ex_stall must stay low under reset even with a MUL presented.
    set_op(4'd9, 32'd3, 32'd4, 5'd1);
    #1;
    chk("rst_stall", 32'(bus.ex_stall), 32'd0);
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    set_nop();
    step();
    reset = 1'b0;
    step();

    // Forwarded ADD: A from EX/MEM, B from MEM/WB.
    set_op(4'd0, 32'd100, 32'd200, 5'd3);
    bus.selMuxRegA = 2'b10; bus.mem_fwd_data = 32'd5;
    bus.selMuxRegB = 2'b01; bus.wb_fwd_data = 32'd7;
    step();
    chk("add_res", bus.mem_alu_result, 32'd12);
    chk("add_valid", 32'(bus.mem_valid), 32'd1);
    chk("add_regd", 32'(bus.mem_regD), 32'd3);
    chk("add_store", bus.mem_store_data, 32'd7);

    set_op(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd4);
    step();
    chk("slt_res", bus.mem_alu_result, 32'd1);

    set_op(4'd8, 32'h8000_0000, 32'd99, 5'd5);
    bus.id_use_imm = 1'b1; bus.id_imm = 32'd4;
    step();
    chk("sra_res", bus.mem_alu_result, 32'hF800_0000);

    set_op(4'd0, 32'd1, 32'd77, 5'd0);
    bus.id_RegW_en = 1'b0; bus.id_mem_wr = 1'b1;
    bus.selMuxRegB = 2'b10; bus.mem_fwd_data = 32'h0000_1234;
    bus.id_use_imm = 1'b1; bus.id_imm = 32'd8;
    step();
    chk("st_data", bus.mem_store_data, 32'h0000_1234);
    chk("st_addr", bus.mem_alu_result, 32'd9);
    chk("st_wr", 32'(bus.mem_mem_wr), 32'd1);

    // MUL 7*6 with forwarding inputs disturbed mid-multiply.
    set_op(4'd9, 32'd7, 32'd6, 5'd9);
    run_mul(5, n);
    chk("mul_stall_len", 32'(n), 32'd33);
    step();
    set_nop();
    chk("mul_res", bus.mem_alu_result, 32'd42);
    chk("mul_regd", 32'(bus.mem_regD), 32'd9);
    chk("mul_valid", 32'(bus.mem_valid), 32'd1);
    step();

    // All-ones squared, held in DONE by a downstream stall.
    set_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    run_mul(-1, n);
    chk("mul2_stall_len", 32'(n), 32'd33);
    bus.stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("done_hold_valid", 32'(bus.mem_valid), 32'd0);
      chk("done_hold_res", bus.mem_alu_result, 32'd0);
    end
    bus.stall_in = 1'b0;
    step();
    set_nop();
    chk("mul2_res", bus.mem_alu_result, 32'd1);
    chk("mul2_regd", 32'(bus.mem_regD), 32'd12);

    // Flush during BUSY discards the multiply.
    set_op(4'd9, 32'd3, 32'd5, 5'd7);
    step();
    repeat (10) step();
    bus.flush = 1'b1;
    step();
    set_nop();
    #1;
    chk("flush_stall", 32'(bus.ex_stall), 32'd0);
    chk("flush_valid", 32'(bus.mem_valid), 32'd0);
    repeat (35) step();
    chk("flush_no_result", 32'(bus.mem_valid), 32'd0);
    set_op(4'd0, 32'd10, 32'd20, 5'd2);
    step();
    chk("pre_flush_add", bus.mem_alu_result, 32'd30);
    set_op(4'd0, 32'd1, 32'd1, 5'd2);
    bus.flush = 1'b1; bus.stall_in = 1'b1;
    step();
    set_nop();
    chk("flush_stall_valid", 32'(bus.mem_valid), 32'd0);
    chk("flush_stall_res", bus.mem_alu_result, 32'd0);

    // Asynchronous reset, off-edge, mid-multiply.
    set_op(4'd0, 32'd4, 32'd4, 5'd6);
    step();
    set_op(4'd9, 32'h1234, 32'h10, 5'd8);
    step();
    repeat (5) step();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", 32'(bus.mem_valid), 32'd0);
    chk("arst_res", bus.mem_alu_result, 32'd0);
    chk("arst_regd", 32'(bus.mem_regD), 32'd0);
    chk("arst_rw", 32'(bus.mem_RegW_en), 32'd0);
    chk("arst_stall", 32'(bus.ex_stall), 32'd0);
    step();
    set_nop();
    reset = 1'b0;
    step();
    set_op(4'd0, 32'd2, 32'd3, 5'd1);
    step();
    set_nop();
    chk("post_rst_add", bus.mem_alu_result, 32'd5);
    repeat (40) step();
    chk("post_rst_quiet", 32'(bus.mem_valid), 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd9 && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 8));
      bus.id_valid     = ($urandom_range(0, 9) != 0);
      bus.id_alu_op    = op;
      bus.id_regA_data = $urandom;
      bus.id_regB_data = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      bus.id_imm       = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      bus.id_use_imm   = 1'($urandom_range(0, 1));
      bus.id_regD      = 5'($urandom_range(0, 31));
      bus.id_RegW_en   = 1'($urandom_range(0, 1));
      bus.id_mem_rd    = 1'($urandom_range(0, 1));
      bus.id_mem_wr    = 1'($urandom_range(0, 1));
      bus.selMuxRegA   = 2'($urandom_range(0, 3));
      bus.selMuxRegB   = 2'($urandom_range(0, 3));
      bus.mem_fwd_data = $urandom;
      bus.wb_fwd_data  = $urandom;
      bus.stall_in     = ($urandom_range(0, 9) == 0);
      bus.flush        = ($urandom_range(0, 39) == 0);
      step();
    end
    set_nop();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
